// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - RV32I memory-stage opcodes, funct3 codes, FSM states and lane helpers
package mem_access_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  // Undefined funct3 codes fall back to a full word access.
  function automatic size_t f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3_size(f3))
      SZ_B:    return 4'b0001 << a;
      SZ_H:    return 4'b0011 << {a[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// rtl/mem_access_if.sv - data-memory req/ack port with byte lanes
interface mem_access_if;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );

endinterface

// File: rtl/mem_access_load_align.sv
// rtl/mem_access_load_align.sv - selects the addressed byte/halfword of a read word and extends it
module mem_access_load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_addr)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_data = {24'd0, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_data = {16'd0, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - RV32I memory stage: dmem load/store FSM, branch resolve, writeback register
// MISALIGN_CHECK_EN: misaligned halfword/word accesses are dropped and pulse o_misalign.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  i_ir,
  input  logic [31:0]  i_alu,
  input  logic         i_comp,
  input  logic [31:0]  i_pc,
  input  logic [31:0]  i_b,
  mem_access_if.master dmem,
  output logic         o_stall,
  output logic [31:0]  o_ir_out,
  output logic [31:0]  o_wb_out,
  output logic         o_take_branch,
  output logic [31:0]  o_branch_target,
  output logic         o_bus_err,
  output logic         o_misalign
);

  localparam int            CW       = $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  state_t        r_state, w_state_next;
  logic [CW-1:0] r_cnt;
  logic          r_req, r_we, r_take, r_bus_err;
  logic [3:0]    r_be;
  logic [31:0]   r_addr, r_wdata, r_ir_out, r_wb_out, r_target;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  size_t       w_size;
  logic        w_is_load, w_is_store, w_is_mem, w_is_branch, w_is_jal, w_is_jalr;
  logic        w_misaligned, w_issue, w_cnt_last, w_stall;
  logic [31:0] w_load_data, w_store_wdata;

  assign w_opcode    = i_ir[6:0];
  assign w_funct3    = i_ir[14:12];
  assign w_size      = f3_size(w_funct3);
  assign w_is_load   = (w_opcode == OP_LOAD);
  assign w_is_store  = (w_opcode == OP_STORE);
  assign w_is_mem    = w_is_load || w_is_store;
  assign w_is_branch = (w_opcode == OP_BRANCH);
  assign w_is_jal    = (w_opcode == OP_JAL);
  assign w_is_jalr   = (w_opcode == OP_JALR);

`ifdef MISALIGN_CHECK_EN
  logic r_misalign;
  assign w_misaligned = w_is_mem && (((w_size == SZ_H) && i_alu[0]) ||
                                     ((w_size == SZ_W) && (i_alu[1:0] != 2'b00)));
  assign o_misalign   = r_misalign;
`else
  assign w_misaligned = 1'b0;
  assign o_misalign   = 1'b0;
`endif

  assign w_issue    = w_is_mem && !w_misaligned;
  assign w_cnt_last = (r_cnt == CNT_LAST);

  always_comb begin
    case (w_size)
      SZ_B:    w_store_wdata = {4{i_b[7:0]}};
      SZ_H:    w_store_wdata = {2{i_b[15:0]}};
      default: w_store_wdata = i_b;
    endcase
  end

  mem_access_load_align u_load_align (
    .i_rdata  (dmem.dmem_rdata),
    .i_addr   (i_alu[1:0]),
    .i_funct3 (w_funct3),
    .o_data   (w_load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_stall      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_issue) begin
          w_stall      = 1'b1;
          w_state_next = ACCESS;
        end
      end
      ACCESS: begin
        w_stall = !dmem.dmem_ack && !w_cnt_last;
        if (dmem.dmem_ack || w_cnt_last) w_state_next = IDLE;
      end
    endcase
  end

  // Upstream must not see a freeze request while the stage is held in reset.
  assign o_stall = w_stall && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_be      <= 4'd0;
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      r_ir_out  <= NOP;
      r_wb_out  <= 32'd0;
      r_take    <= 1'b0;
      r_target  <= 32'd0;
      r_bus_err <= 1'b0;
`ifdef MISALIGN_CHECK_EN
      r_misalign <= 1'b0;
`endif
    end else begin
      // Any edge that does not retire an instruction hands writeback a bubble.
      r_ir_out  <= NOP;
      r_wb_out  <= 32'd0;
      r_take    <= 1'b0;
      r_target  <= 32'd0;
      r_bus_err <= 1'b0;
`ifdef MISALIGN_CHECK_EN
      r_misalign <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_req   <= 1'b1;
            r_we    <= w_is_store;
            r_addr  <= {i_alu[31:2], 2'b00};
            r_be    <= lane_be(w_funct3, i_alu[1:0]);
            r_wdata <= w_store_wdata;
            r_cnt   <= '0;
`ifdef MISALIGN_CHECK_EN
          end else if (w_is_mem) begin
            r_misalign <= 1'b1;
`endif
          end else begin
            r_ir_out <= i_ir;
            r_wb_out <= (w_is_jal || w_is_jalr) ? i_pc + 32'd4 : i_alu;
            r_take   <= w_is_branch ? i_comp : (w_is_jal || w_is_jalr);
            r_target <= w_is_jalr ? (i_alu & ~32'd1) :
                        (w_is_branch || w_is_jal) ? i_alu : 32'd0;
          end
        end
        ACCESS: begin
          if (dmem.dmem_ack) begin
            r_req    <= 1'b0;
            r_ir_out <= i_ir;
            r_wb_out <= w_is_load ? w_load_data : 32'd0;
          end else if (w_cnt_last) begin
            r_req     <= 1'b0;
            r_bus_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign dmem.dmem_req   = r_req;
  assign dmem.dmem_we    = r_we;
  assign dmem.dmem_addr  = r_addr;
  assign dmem.dmem_be    = r_be;
  assign dmem.dmem_wdata = r_wdata;

  assign o_ir_out        = r_ir_out;
  assign o_wb_out        = r_wb_out;
  assign o_take_branch   = r_take;
  assign o_branch_target = r_target;
  assign o_bus_err       = r_bus_err;

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - self-checking bench for mem_access against a behavioural stage model
module tb_mem_access;

  localparam int          TMO  = 16;
  localparam logic [31:0] NOPI = 32'h00000013;
`ifdef MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ir = NOPI, alu = 32'd0, pc = 32'd0, b = 32'd0;
  logic        comp = 1'b0;
  logic        stall, tb_o, berr_o, mis_o;
  logic [31:0] ir_o, wb_o, tgt_o;

  mem_access_if dmem();

  mem_access #(.MEM_TIMEOUT(TMO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_ir            (ir),
    .i_alu           (alu),
    .i_comp          (comp),
    .i_pc            (pc),
    .i_b             (b),
    .dmem            (dmem),
    .o_stall         (stall),
    .o_ir_out        (ir_o),
    .o_wb_out        (wb_o),
    .o_take_branch   (tb_o),
    .o_branch_target (tgt_o),
    .o_bus_err       (berr_o),
    .o_misalign      (mis_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ir, wb, tgt, addr, wdata;
    logic [3:0]  be;
    logic        tb, berr, mis, we, iss;
    int          n;
  } exp_t;

  int n_err = 0, n_checks = 0;
  int n_stall, n_req;

  logic        chk_on = 1'b0;
  logic        e_stall, e_req, e_bus, e_res, e_berr, e_mis, e_we, e_tb;
  logic [31:0] e_addr, e_wdata, e_ir, e_wb, e_tgt;
  logic [3:0]  e_be;

  exp_t pend;
  bit   p_valid = 1'b0;

  bit          l_en = 1'b0;
  logic [31:0] l_ir, l_wb, l_tgt;
  logic        l_tb, l_berr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Stage outcome computed from the instruction-level rules with plain arithmetic.
  function automatic exp_t predict(input logic [31:0] i_ir, a, input logic c,
                                   input logic [31:0] p, bv, rd, input int k);
    exp_t   e;
    logic [6:0] op;
    int     size, off;
    longint v, full;
    bit     ld, st, br, jal, jalr, uns, mis;
    op   = i_ir[6:0];
    ld   = (op == 7'h03);
    st   = (op == 7'h23);
    br   = (op == 7'h63);
    jal  = (op == 7'h6F);
    jalr = (op == 7'h67);
    case (i_ir[13:12])
      2'd0:    size = 1;
      2'd1:    size = 2;
      default: size = 4;
    endcase
    uns = i_ir[14] && (size < 4);
    mis = MIS_EN && (ld || st) && ((size == 2 && a % 2 != 0) || (size == 4 && a % 4 != 0));
    off = (size == 1) ? int'(a % 4) : (size == 2) ? int'((a % 4) / 2 * 2) : 0;
    e.addr  = a - a % 4;
    e.be    = 4'(((1 << size) - 1) << off);
    e.wdata = (size == 1) ? 32'(bv[7:0]) * 32'h01010101 :
              (size == 2) ? 32'(bv[15:0]) * 32'h00010001 : bv;
    full = longint'(1) << (8 * size);
    v    = (longint'(rd) >> (8 * off)) % full;
    if (!uns && size < 4 && v >= full / 2) v = v - full;
    e.we   = st;
    e.iss  = (ld || st) && !mis;
    e.mis  = mis;
    e.berr = 1'b0;
    e.tb   = 1'b0;
    e.tgt  = 32'd0;
    if (mis) begin
      e.ir = NOPI; e.wb = 32'd0; e.n = 1;
    end else if (e.iss && (k == 0 || k > TMO)) begin
      e.ir = NOPI; e.wb = 32'd0; e.berr = 1'b1; e.n = 1 + TMO;
    end else if (e.iss) begin
      e.ir = i_ir; e.wb = ld ? 32'(v) : 32'd0; e.n = 1 + k;
    end else begin
      e.ir  = i_ir;
      e.wb  = (jal || jalr) ? p + 32'd4 : a;
      e.tb  = br ? c : (jal || jalr);
      e.tgt = jalr ? {a[31:1], 1'b0} : (br || jal) ? a : 32'd0;
      e.n   = 1;
    end
    return e;
  endfunction

  task automatic expect_lit(input logic [31:0] i_ir, wb, input logic tbv,
                            input logic [31:0] tgt, input logic berr);
    l_en = 1'b1; l_ir = i_ir; l_wb = wb; l_tb = tbv; l_tgt = tgt; l_berr = berr;
  endtask

  // k = ACCESS cycle carrying dmem_ack (0: never); stray drives ack in the IDLE cycle.
  task automatic run_op(input logic [31:0] i_ir, a, input logic c, input logic [31:0] p, bv, rd,
                        input int k, input bit stray);
    exp_t e;
    e = predict(i_ir, a, c, p, bv, rd, k);
    n_stall = 0;
    n_req   = 0;
    for (int cy = 0; cy < e.n; cy++) begin
      @(posedge clk); #1;
      ir = i_ir; alu = a; comp = c; pc = p; b = bv;
      dmem.dmem_rdata = rd;
      dmem.dmem_ack   = (cy > 0 && cy == k) || (cy == 0 && stray);
      e_stall = e.iss && (cy < e.n - 1);
      e_req   = (cy > 0);
      e_bus   = (cy > 0);
      e_addr  = e.addr; e_be = e.be; e_wdata = e.wdata; e_we = e.we;
      e_res   = (cy == 0) && p_valid;
      e_ir    = pend.ir; e_wb = pend.wb; e_tb = pend.tb; e_tgt = pend.tgt;
      e_berr  = (cy == 0 && p_valid) ? pend.berr : 1'b0;
      e_mis   = (cy == 0 && p_valid) ? pend.mis : 1'b0;
      @(negedge clk); #1;
      n_stall += int'(stall);
      n_req   += int'(dmem.dmem_req);
      if (cy == 0 && l_en) begin
        check("lit_ir_out", ir_o, l_ir);
        check("lit_wb_out", wb_o, l_wb);
        check("lit_take_branch", tb_o, l_tb);
        check("lit_target", tgt_o, l_tgt);
        check("lit_bus_err", berr_o, l_berr);
        l_en = 1'b0;
      end
    end
    pend    = e;
    p_valid = 1'b1;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("stall", stall, e_stall);
      check("dmem_req", dmem.dmem_req, e_req);
      check("bus_err", berr_o, e_berr);
      check("misalign", mis_o, e_mis);
      if (e_bus) begin
        check("dmem_addr", dmem.dmem_addr, e_addr);
        check("dmem_be", dmem.dmem_be, e_be);
        check("dmem_wdata", dmem.dmem_wdata, e_wdata);
        check("dmem_we", dmem.dmem_we, e_we);
      end
      if (e_res) begin
        check("ir_out", ir_o, e_ir);
        check("wb_out", wb_o, e_wb);
        check("take_branch", tb_o, e_tb);
        check("branch_target", tgt_o, e_tgt);
      end
    end
  end

  initial begin
    dmem.dmem_ack   = 1'b0;
    dmem.dmem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ir_out", ir_o, NOPI);
    check("rst_wb_out", wb_o, 32'd0);
    check("rst_take_branch", tb_o, 1'b0);
    check("rst_target", tgt_o, 32'd0);
    check("rst_req", dmem.dmem_req, 1'b0);
    check("rst_we", dmem.dmem_we, 1'b0);
    check("rst_be", dmem.dmem_be, 4'd0);
    check("rst_addr", dmem.dmem_addr, 32'd0);
    check("rst_wdata", dmem.dmem_wdata, 32'd0);
    check("rst_stall", stall, 1'b0);
    check("rst_bus_err", berr_o, 1'b0);
    check("rst_misalign", mis_o, 1'b0);
    rst_n  = 1'b1;
    chk_on = 1'b1;

    //     IR            ALU           C     PC            B             RDATA         K   STRAY
    run_op(32'h00500093, 32'h00000005, 1'b0, 32'h00000010, 32'h0,        32'h0,        0,  1'b1);
    run_op(32'h00000063, 32'h00000200, 1'b1, 32'h00000020, 32'h0,        32'h0,        0,  1'b0);
    expect_lit(32'h00000063, 32'h00000200, 1'b1, 32'h00000200, 1'b0);
    run_op(32'h00000063, 32'h00000200, 1'b0, 32'h00000024, 32'h0,        32'h0,        0,  1'b0);
    expect_lit(32'h00000063, 32'h00000200, 1'b0, 32'h00000200, 1'b0);
    run_op(32'h000000EF, 32'h00001000, 1'b0, 32'h00000080, 32'h0,        32'h0,        0,  1'b0);
    run_op(32'h000000E7, 32'h00000301, 1'b0, 32'h00000040, 32'h0,        32'h0,        0,  1'b0);
    expect_lit(32'h000000E7, 32'h00000044, 1'b1, 32'h00000300, 1'b0);

    run_op(32'h00002023, 32'h00000100, 1'b0, 32'h00000044, 32'hDEADBEEF, 32'h0,        3,  1'b0);
    check("sw_stall_cycles", n_stall, 32'd3);
    check("sw_req_cycles", n_req, 32'd3);
    run_op(32'h00000083, 32'h00000103, 1'b0, 32'h00000048, 32'h0,        32'h80123456, 1,  1'b0);
    expect_lit(32'h00000083, 32'hFFFFFF80, 1'b0, 32'h0, 1'b0);
    run_op(32'h00004083, 32'h00000103, 1'b0, 32'h0000004C, 32'h0,        32'h80123456, 2,  1'b1);
    expect_lit(32'h00004083, 32'h00000080, 1'b0, 32'h0, 1'b0);
    run_op(32'h00001083, 32'h00000102, 1'b0, 32'h00000050, 32'h0,        32'h80123456, 1,  1'b0);
    expect_lit(32'h00001083, 32'hFFFF8012, 1'b0, 32'h0, 1'b0);
    run_op(32'h00005083, 32'h00000100, 1'b0, 32'h00000054, 32'h0,        32'h80123456, 1,  1'b0);
    run_op(32'h00000023, 32'h00000102, 1'b0, 32'h00000058, 32'h000000A5, 32'h0,        2,  1'b0);
    run_op(32'h00001023, 32'h00000103, 1'b0, 32'h0000005C, 32'h1234BEEF, 32'h0,        1,  1'b0);
    run_op(32'h00002083, 32'h00000102, 1'b0, 32'h00000060, 32'h0,        32'hCAFEF00D, 1,  1'b0);
    check("lw102_req_cycles", n_req, MIS_EN ? 32'd0 : 32'd1);
    run_op(32'h00003083, 32'h00000104, 1'b0, 32'h00000064, 32'h0,        32'h11223344, 1,  1'b0);
    run_op(32'h00002083, 32'h00000200, 1'b0, 32'h00000068, 32'h0,        32'h55555555, 0,  1'b0);
    check("tmo_stall_cycles", n_stall, 32'd16);
    check("tmo_req_cycles", n_req, 32'd16);
    expect_lit(NOPI, 32'h0, 1'b0, 32'h0, 1'b1);
    run_op(32'h00002083, 32'h00000204, 1'b0, 32'h0000006C, 32'h0,        32'h0BADF00D, 16, 1'b0);
    expect_lit(32'h00002083, 32'h0BADF00D, 1'b0, 32'h0, 1'b0);
    run_op(NOPI,         32'h00000000, 1'b0, 32'h00000070, 32'h0,        32'h0,        0,  1'b0);
    chk_on = 1'b0;

    // Reset asserted between edges while an access is outstanding.
    @(posedge clk); #1;
    ir = 32'h00002083; alu = 32'h00000300; dmem.dmem_ack = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("pre_rst_req", dmem.dmem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_req", dmem.dmem_req, 1'b0);
    check("midrst_ir_out", ir_o, NOPI);
    check("midrst_stall", stall, 1'b0);
    check("midrst_bus_err", berr_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
